// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM/WB hazard inputs towards the
// controller and stage enables, flushes, forward selects and status back.
//
// Signals (named from the controller side):
//   i_id_*      ID source registers and their use flags
//   i_ex_*      EX load flag, destination, forwarding sources, branch flush
//   i_mem_*     MEM write-back info, memory access and busy
//   i_wb_*      WB write-back info
//   i_halt_req  debug halt request (level)
//   o_*_clk_en  per-stage register enables
//   o_*_flush   NOP insertion into IF-ID / ID-EX
//   o_fwd_a/b   EX operand select: 00 regfile, 10 MEM, 01 WB
//   o_halted, o_bus_error, o_stall_cycles  registered status
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR = 5,
    parameter int CNT_W    = 32
);
    logic [REG_ADDR-1:0] i_id_rs1;
    logic [REG_ADDR-1:0] i_id_rs2;
    logic                i_id_use_rs1;
    logic                i_id_use_rs2;
    logic                i_ex_mem_rd;
    logic [REG_ADDR-1:0] i_ex_reg_destination;
    logic [REG_ADDR-1:0] i_ex_rs1;
    logic [REG_ADDR-1:0] i_ex_rs2;
    logic                i_mem_reg_wr;
    logic [REG_ADDR-1:0] i_mem_reg_destination;
    logic                i_wb_reg_wr;
    logic [REG_ADDR-1:0] i_wb_reg_destination;
    logic                i_ex_flush;
    logic                i_mem_access;
    logic                i_dmem_busy;
    logic                i_halt_req;

    logic                o_if_clk_en;
    logic                o_id_clk_en;
    logic                o_ex_clk_en;
    logic                o_mem_clk_en;
    logic                o_if_flush;
    logic                o_id_flush;
    logic [1:0]          o_fwd_a;
    logic [1:0]          o_fwd_b;
    logic                o_halted;
    logic                o_bus_error;
    logic [CNT_W-1:0]    o_stall_cycles;

    // Pipeline side: drives hazard info, consumes controls.
    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        output i_ex_mem_rd, i_ex_reg_destination, i_ex_rs1, i_ex_rs2,
        output i_mem_reg_wr, i_mem_reg_destination,
        output i_wb_reg_wr, i_wb_reg_destination,
        output i_ex_flush, i_mem_access, i_dmem_busy, i_halt_req,
        input  o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_mem_clk_en,
        input  o_if_flush, o_id_flush, o_fwd_a, o_fwd_b,
        input  o_halted, o_bus_error, o_stall_cycles
    );

    // Controller side.
    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        input  i_ex_mem_rd, i_ex_reg_destination, i_ex_rs1, i_ex_rs2,
        input  i_mem_reg_wr, i_mem_reg_destination,
        input  i_wb_reg_wr, i_wb_reg_destination,
        input  i_ex_flush, i_mem_access, i_dmem_busy, i_halt_req,
        output o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_mem_clk_en,
        output o_if_flush, o_id_flush, o_fwd_a, o_fwd_b,
        output o_halted, o_bus_error, o_stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage RV32I pipeline sequencer: forwarding selects, load-use stalls,
// branch flushes, data-memory wait / timeout and debug halt-drain.
//
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   pipeline_hazard_ctrl_if.slave (hazard inputs, stage controls,
//         forward selects, halted / bus-error / stall-count status)
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR     = 5,
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [REG_ADDR-1:0] X0      = '0;
    localparam logic [WT_W-1:0]     WT_LAST = WT_W'(MEM_TIMEOUT - 1);
    localparam logic [DR_W-1:0]     DR_LAST = DR_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT,
        ST_DRAIN,
        ST_HALT,
        ST_ERR
    } state_t;

    state_t           r_state;
    state_t           r_ret;
    state_t           w_next;
    state_t           w_mode;
    logic [WT_W-1:0]  r_wait_cnt;
    logic [DR_W-1:0]  r_drain_cnt;
    logic             r_halted;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_stall;

    logic             w_wait;
    logic             w_fl;
    logic             w_lu;
    logic             w_live;
    logic             w_stall;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_mem_a;
    logic             w_mem_b;
    logic             w_wb_a;
    logic             w_wb_b;

    logic             w_if_en;
    logic             w_id_en;
    logic             w_ex_en;
    logic             w_mem_en;
    logic             w_if_fl;
    logic             w_id_fl;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    // ---------------- hazard detection ----------------
    assign w_wait = bus.i_mem_access && bus.i_dmem_busy;
    assign w_fl   = bus.i_ex_flush;

    assign w_rs1_hit = bus.i_id_use_rs1 &&
                       (bus.i_id_rs1 == bus.i_ex_reg_destination);
    assign w_rs2_hit = bus.i_id_use_rs2 &&
                       (bus.i_id_rs2 == bus.i_ex_reg_destination);
    assign w_lu = bus.i_ex_mem_rd &&
                  (bus.i_ex_reg_destination != X0) &&
                  (w_rs1_hit || w_rs2_hit);

    assign w_mem_a = bus.i_mem_reg_wr && (bus.i_ex_rs1 != X0) &&
                     (bus.i_mem_reg_destination == bus.i_ex_rs1);
    assign w_mem_b = bus.i_mem_reg_wr && (bus.i_ex_rs2 != X0) &&
                     (bus.i_mem_reg_destination == bus.i_ex_rs2);
    assign w_wb_a  = bus.i_wb_reg_wr && (bus.i_ex_rs1 != X0) &&
                     (bus.i_wb_reg_destination == bus.i_ex_rs1);
    assign w_wb_b  = bus.i_wb_reg_wr && (bus.i_ex_rs2 != X0) &&
                     (bus.i_wb_reg_destination == bus.i_ex_rs2);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (!rst) begin
            if (w_mem_a)     w_fwd_a = 2'b10;
            else if (w_wb_a) w_fwd_a = 2'b01;
            if (w_mem_b)     w_fwd_b = 2'b10;
            else if (w_wb_b) w_fwd_b = 2'b01;
        end
    end

    // While waiting on memory, behave as the state that was interrupted;
    // the cycle busy drops therefore already looks like RUN / DRAIN.
    assign w_mode = (r_state == ST_WAIT) ? r_ret : r_state;
    assign w_live = (r_state == ST_RUN) || (r_state == ST_WAIT) ||
                    (r_state == ST_DRAIN);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_ret   <= ST_RUN;
        end else begin
            r_state <= w_next;
            if ((r_state != ST_WAIT) && (w_next == ST_WAIT))
                r_ret <= r_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_ERR: w_next = ST_ERR;
            ST_HALT: begin
                if (!bus.i_halt_req) w_next = ST_RUN;
            end
            default: begin
                if (w_wait) begin
                    w_next = (r_wait_cnt == WT_LAST) ? ST_ERR : ST_WAIT;
                end else if (w_mode == ST_DRAIN) begin
                    if (!bus.i_halt_req)            w_next = ST_RUN;
                    else if (w_fl || w_lu)          w_next = ST_DRAIN;
                    else if (r_drain_cnt == DR_LAST) w_next = ST_HALT;
                    else                            w_next = ST_DRAIN;
                end else begin
                    // Halt waits behind a pending flush or load-use bubble.
                    if (bus.i_halt_req && !w_fl && !w_lu)
                        w_next = ST_DRAIN;
                    else
                        w_next = ST_RUN;
                end
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_if_en  = 1'b1;
        w_id_en  = 1'b1;
        w_ex_en  = 1'b1;
        w_mem_en = 1'b1;
        w_if_fl  = 1'b0;
        w_id_fl  = 1'b0;
        if (!rst) begin
            if (!w_live || w_wait) begin
                w_if_en  = 1'b0;
                w_id_en  = 1'b0;
                w_ex_en  = 1'b0;
                w_mem_en = 1'b0;
            end else if (w_mode == ST_DRAIN) begin
                w_if_en = 1'b0;
                if (w_fl) begin
                    w_if_fl = 1'b1;
                    w_id_fl = 1'b1;
                end else if (w_lu) begin
                    // Keep the stalled consumer in IF-ID intact.
                    w_id_en = 1'b0;
                    w_id_fl = 1'b1;
                end else begin
                    w_if_fl = 1'b1;
                end
            end else begin
                if (w_fl) begin
                    w_if_fl = 1'b1;
                    w_id_fl = 1'b1;
                end else if (w_lu) begin
                    w_if_en = 1'b0;
                    w_id_en = 1'b0;
                    w_id_fl = 1'b1;
                end
            end
        end
    end

    // Stalls are memory waits and load-use bubbles; drain bubbles are not.
    assign w_stall = w_live &&
                     (w_wait || ((w_mode == ST_RUN) && !w_fl && w_lu));

    // ---------------- counters and status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_stall     <= '0;
        end else begin
            if (w_wait && w_live)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            if (w_live && !w_wait) begin
                if (w_mode == ST_RUN)
                    r_drain_cnt <= '0;
                else if (w_fl)
                    r_drain_cnt <= '0;
                else if (!w_lu)
                    r_drain_cnt <= r_drain_cnt + 1'b1;
            end

            r_halted  <= (w_next == ST_HALT);
            r_bus_err <= (w_next == ST_ERR);

            if (w_stall && (r_stall != '1))
                r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.o_if_clk_en    = w_if_en;
    assign bus.o_id_clk_en    = w_id_en;
    assign bus.o_ex_clk_en    = w_ex_en;
    assign bus.o_mem_clk_en   = w_mem_en;
    assign bus.o_if_flush     = w_if_fl;
    assign bus.o_id_flush     = w_id_fl;
    assign bus.o_fwd_a        = w_fwd_a;
    assign bus.o_fwd_b        = w_fwd_b;
    assign bus.o_halted       = r_halted;
    assign bus.o_bus_error    = r_bus_err;
    assign bus.o_stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the
// combinational controls plus hand sequences for wait, halt and reset.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    pipeline_hazard_ctrl_if #(.REG_ADDR(5), .CNT_W(32)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR    (5),
        .MEM_TIMEOUT (8),
        .DRAIN_CYCLES(4),
        .CNT_W       (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {if_en, id_en, ex_en, mem_en, if_flush, id_flush}
    localparam logic [5:0] NRM = 6'b111100;
    localparam logic [5:0] LU  = 6'b001101;
    localparam logic [5:0] FL  = 6'b111111;
    localparam logic [5:0] OFF = 6'b000000;
    localparam logic [5:0] DRN = 6'b011110;
    localparam logic [5:0] DFL = 6'b011111;

    logic [5:0] w_ctl;
    assign w_ctl = {bus.o_if_clk_en, bus.o_id_clk_en, bus.o_ex_clk_en,
                    bus.o_mem_clk_en, bus.o_if_flush, bus.o_id_flush};

    typedef struct {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       use1;
        logic       use2;
        logic       ld;
        logic [4:0] ex_rd;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic       mem_wr;
        logic [4:0] mem_rd;
        logic       wb_wr;
        logic [4:0] wb_rd;
        logic       flush;
        logic [5:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_id_rs1              = '0;
        bus.i_id_rs2              = '0;
        bus.i_id_use_rs1          = 1'b0;
        bus.i_id_use_rs2          = 1'b0;
        bus.i_ex_mem_rd           = 1'b0;
        bus.i_ex_reg_destination  = '0;
        bus.i_ex_rs1              = '0;
        bus.i_ex_rs2              = '0;
        bus.i_mem_reg_wr          = 1'b0;
        bus.i_mem_reg_destination = '0;
        bus.i_wb_reg_wr           = 1'b0;
        bus.i_wb_reg_destination  = '0;
        bus.i_ex_flush            = 1'b0;
        bus.i_mem_access          = 1'b0;
        bus.i_dmem_busy           = 1'b0;
        bus.i_halt_req            = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.i_id_rs1              = v.id_rs1;
        bus.i_id_rs2              = v.id_rs2;
        bus.i_id_use_rs1          = v.use1;
        bus.i_id_use_rs2          = v.use2;
        bus.i_ex_mem_rd           = v.ld;
        bus.i_ex_reg_destination  = v.ex_rd;
        bus.i_ex_rs1              = v.ex_rs1;
        bus.i_ex_rs2              = v.ex_rs2;
        bus.i_mem_reg_wr          = v.mem_wr;
        bus.i_mem_reg_destination = v.mem_rd;
        bus.i_wb_reg_wr           = v.wb_wr;
        bus.i_wb_reg_destination  = v.wb_rd;
        bus.i_ex_flush            = v.flush;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // id_rs1 id_rs2 u1 u2 ld ex_rd ex_rs1 ex_rs2 mw mrd ww wrd fl ctl fa fb
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00};
        tbl[1]  = '{5, 0, 1, 0, 0, 0, 5, 0, 1, 5, 0, 0, 0, NRM, 2'b10, 2'b00};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 5, 0, NRM, 2'b01, 2'b00};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, NRM, 2'b00, 2'b00};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 3, 3, 1, 3, 1, 3, 0, NRM, 2'b10, 2'b10};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 6, 4, 1, 4, 1, 6, 0, NRM, 2'b01, 2'b10};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 9, 9, 0, 9, 0, 9, 0, NRM, 2'b00, 2'b00};
        tbl[7]  = '{1, 7, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, LU,  2'b00, 2'b00};
        tbl[8]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00};
        tbl[9]  = '{2, 7, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00};
        tbl[10] = '{7, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, FL,  2'b00, 2'b00};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL,  2'b00, 2'b00};
        tbl[12] = '{7, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00};
        tbl[13] = '{8, 0, 1, 0, 1, 8, 0, 2, 0, 0, 1, 2, 0, LU,  2'b00, 2'b01};

        // Reset overrides every hazard source.
        rst = 1'b1;
        idle();
        apply('{7, 0, 1, 0, 1, 7, 7, 7, 1, 7, 0, 0, 1, NRM, 2'b00, 2'b00});
        bus.i_mem_access = 1'b1;
        bus.i_dmem_busy  = 1'b1;
        @(negedge clk);
        chk("rst ctl", 32'(w_ctl), 32'(NRM));
        chk("rst fwd", 32'({bus.o_fwd_a, bus.o_fwd_b}), 32'h0);
        step();
        rst = 1'b0;
        idle();
        chk("rst halted", 32'(bus.o_halted), 0);
        chk("rst buserr", 32'(bus.o_bus_error), 0);
        chk("rst stall", bus.o_stall_cycles, 0);

        // Combinational vector table, all in RUN.
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d ctl", i), 32'(w_ctl), 32'(tbl[i].ctl));
            chk($sformatf("vec%0d fwd_a", i), 32'(bus.o_fwd_a), 32'(tbl[i].fa));
            chk($sformatf("vec%0d fwd_b", i), 32'(bus.o_fwd_b), 32'(tbl[i].fb));
            step();
        end
        idle();
        chk("lu stall cnt", bus.o_stall_cycles, 2);

        // Memory wait: three busy cycles, resume on the fourth.
        bus.i_mem_access = 1'b1;
        bus.i_dmem_busy  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("wait%0d ctl", k), 32'(w_ctl), 32'(OFF));
            step();
        end
        bus.i_dmem_busy = 1'b0;
        @(negedge clk);
        chk("wait resume ctl", 32'(w_ctl), 32'(NRM));
        step();
        bus.i_mem_access = 1'b0;
        chk("wait stall cnt", bus.o_stall_cycles, 5);

        // Halt held: RUN cycle, four drain cycles, then halted.
        bus.i_halt_req = 1'b1;
        @(negedge clk);
        chk("halt req ctl", 32'(w_ctl), 32'(NRM));
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d ctl", k), 32'(w_ctl), 32'(DRN));
            chk($sformatf("drain%0d halted", k), 32'(bus.o_halted), 0);
            step();
        end
        chk("halted set", 32'(bus.o_halted), 1);
        @(negedge clk);
        chk("halted ctl", 32'(w_ctl), 32'(OFF));
        step();
        bus.i_halt_req = 1'b0;
        @(negedge clk);
        chk("halted hold", 32'(bus.o_halted), 1);
        step();
        chk("halted clear", 32'(bus.o_halted), 0);
        @(negedge clk);
        chk("unhalt ctl", 32'(w_ctl), 32'(NRM));
        step();

        // Halt dropped during drain cycle 2: back to RUN, never halts.
        bus.i_halt_req = 1'b1;
        step();
        step();
        bus.i_halt_req = 1'b0;
        @(negedge clk);
        chk("drop drain ctl", 32'(w_ctl), 32'(DRN));
        step();
        @(negedge clk);
        chk("drop run ctl", 32'(w_ctl), 32'(NRM));
        step();
        step();
        step();
        chk("drop no halt", 32'(bus.o_halted), 0);

        // Flush during drain restarts the drain count.
        bus.i_halt_req = 1'b1;
        step();
        step();
        step();
        bus.i_ex_flush = 1'b1;
        @(negedge clk);
        chk("drain flush ctl", 32'(w_ctl), 32'(DFL));
        step();
        bus.i_ex_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("restart%0d halted", k), 32'(bus.o_halted), 0);
        end
        step();
        chk("restart halted", 32'(bus.o_halted), 1);
        chk("drain stall cnt", bus.o_stall_cycles, 5);

        // Reset while halted.
        rst = 1'b1;
        bus.i_halt_req = 1'b0;
        @(negedge clk);
        chk("rst halt ctl", 32'(w_ctl), 32'(NRM));
        step();
        rst = 1'b0;
        chk("rst halt halted", 32'(bus.o_halted), 0);
        chk("rst halt stall", bus.o_stall_cycles, 0);
        @(negedge clk);
        chk("rst halt run", 32'(w_ctl), 32'(NRM));
        step();

        // Timeout after eight busy cycles; error is sticky.
        bus.i_mem_access = 1'b1;
        bus.i_dmem_busy  = 1'b1;
        for (int k = 0; k < 7; k++) step();
        chk("to early", 32'(bus.o_bus_error), 0);
        step();
        chk("to set", 32'(bus.o_bus_error), 1);
        bus.i_mem_access = 1'b0;
        bus.i_dmem_busy  = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("to sticky", 32'(bus.o_bus_error), 1);
        chk("to ctl", 32'(w_ctl), 32'(OFF));
        chk("to stall cnt", bus.o_stall_cycles, 8);
        step();

        // Reset while in error.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst err buserr", 32'(bus.o_bus_error), 0);
        chk("rst err stall", bus.o_stall_cycles, 0);
        chk("rst err halted", 32'(bus.o_halted), 0);
        @(negedge clk);
        chk("rst err ctl", 32'(w_ctl), 32'(NRM));
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage RV32I pipeline.
- Detects data hazards and drives the forwarding mux selects used by the execution stage.
- Generates per-stage clk_en and flush/bubble controls for load-use stalls, taken-branch flushes (execution-stage o_ex_flush), data-memory wait states and debug halt.
- Holds an FSM for memory wait, timeout error and halt/drain sequencing, plus a stall-cycle counter.

Parameters:
- REG_ADDR, 5, register address width.
- MEM_TIMEOUT, 255, maximum consecutive i_dmem_busy cycles before bus error.
- DRAIN_CYCLES, 4, bubble cycles issued after a halt request before declaring halted.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_id_rs1  in  REG_ADDR  source register 1 of the instruction in ID.
- i_id_rs2  in  REG_ADDR  source register 2 of the instruction in ID.
- i_id_use_rs1  in  1  ID instruction reads rs1.
- i_id_use_rs2  in  1  ID instruction reads rs2.
- i_ex_mem_rd  in  1  EX instruction is a load.
- i_ex_reg_destination  in  REG_ADDR  EX destination register.
- i_ex_rs1  in  REG_ADDR  EX source register 1 (forwarding compare).
- i_ex_rs2  in  REG_ADDR  EX source register 2 (forwarding compare).
- i_mem_reg_wr  in  1  MEM stage writes the register file.
- i_mem_reg_destination  in  REG_ADDR  MEM destination register.
- i_wb_reg_wr  in  1  WB stage writes the register file.
- i_wb_reg_destination  in  REG_ADDR  WB destination register.
- i_ex_flush  in  1  taken branch/jump resolved in EX.
- i_mem_access  in  1  MEM stage holds a load or store.
- i_dmem_busy  in  1  data memory not ready.
- i_halt_req  in  1  debug halt request (level).
- o_if_clk_en  out  1  PC/IF-ID register enable.
- o_id_clk_en  out  1  ID-EX register enable.
- o_ex_clk_en  out  1  EX-MEM register enable.
- o_mem_clk_en  out  1  MEM-WB register enable.
- o_if_flush  out  1  load NOP into IF-ID.
- o_id_flush  out  1  load NOP into ID-EX (bubble).
- o_fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM, 01 WB.
- o_fwd_b  out  2  EX operand B select, same encoding.
- o_halted  out  1  pipeline halted.
- o_bus_error  out  1  memory timeout; sticky until rst.
- o_stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- All outputs are combinational from state and inputs except o_halted, o_bus_error, o_stall_cycles, which are registered.
- Forwarding (combinational in all states):
  - o_fwd_a = 10 if i_mem_reg_wr && i_mem_reg_destination==i_ex_rs1 && i_ex_rs1!=0.
  - Else o_fwd_a = 01 if the same condition holds for WB.
  - Else o_fwd_a = 00. o_fwd_b uses the same rules with i_ex_rs2.
  - MEM has priority over WB. x0 never forwards.
- Load-use hazard (LU): i_ex_mem_rd && i_ex_reg_destination!=0 && ((i_id_use_rs1 && rs1 match) || (i_id_use_rs2 && rs2 match)).
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED, ERROR. Reset state is RUN.
- Evaluation priority: ERROR > busy > flush > LU > halt.
- MEM_WAIT condition: i_mem_access && i_dmem_busy.
  - All four clk_en are 0 and both flushes are 0.
  - From RUN or DRAIN, entered the same cycle the condition is seen.
  - A wait counter increments each cycle in MEM_WAIT.
  - Return to the previous state (RUN or DRAIN, saved) the cycle after busy drops, with the counter cleared.
  - Counter reaching MEM_TIMEOUT: go to ERROR.
- ERROR: all clk_en 0, o_bus_error=1. Exit only via rst.
- RUN:
  - Default: all clk_en=1, flushes=0.
  - i_ex_flush: o_if_flush=1, o_id_flush=1. An LU in the same cycle is ignored (its consumer is being flushed).
  - LU without flush: o_if_clk_en=0, o_id_clk_en=0, o_id_flush=1 for exactly one cycle. The next cycle the load is in MEM and the WB forward resolves it.
  - i_halt_req without busy: go to DRAIN with the drain counter set to 0.
- DRAIN:
  - o_if_clk_en=0, o_if_flush=1, so bubbles enter ID. Other stages advance.
  - Flush and LU are handled as in RUN. A flush restarts the drain counter.
  - The counter increments each cycle. At DRAIN_CYCLES-1: go to HALTED.
  - i_halt_req deasserted: return to RUN the next cycle.
- HALTED:
  - All clk_en 0, o_halted=1 (registered, asserted the first cycle in HALTED).
  - i_halt_req low: go to RUN. o_halted clears the same edge.
- o_stall_cycles increments on every cycle in which o_if_clk_en=0 in RUN or MEM_WAIT. It saturates at all-ones.
- While rst is high:
  - All clk_en=1, flushes=0, fwd=00, so stage registers apply their own reset.
  - On the next clock: state=RUN, counters=0, o_halted=0, o_bus_error=0.
  - rst mid-MEM_WAIT/DRAIN/ERROR aborts to RUN.

Test Plan:
- EX add x5, ID uses rs1=x5 -> o_fwd_a=10 for one cycle. Next cycle (x5 in WB, ex_rs1=x5) -> o_fwd_a=01. With rd=x0 -> 00.
- EX load x7, ID rs2=x7 -> one cycle with o_if_clk_en=0, o_id_clk_en=0, o_id_flush=1, then all enables back to 1. o_stall_cycles=1.
- Load-use and i_ex_flush in the same cycle -> o_if_flush=o_id_flush=1, all clk_en=1, no stall.
- i_mem_access=1 with i_dmem_busy=1 for 3 cycles -> all clk_en=0 for 3 cycles, RUN resumes on the 4th, o_stall_cycles=3. With MEM_TIMEOUT=8 and busy held 8 cycles -> o_bus_error=1, sticky until rst.
- i_halt_req held -> 4 cycles with o_if_flush=1, then o_halted=1 with all clk_en=0. Drop the request -> RUN and o_halted=0 next cycle. Drop the request during DRAIN cycle 2 -> RUN, no halt.
- rst asserted in HALTED and in ERROR -> next cycle RUN, o_halted=0, o_bus_error=0, o_stall_cycles=0.
